// File: rtl/audio_pkg.sv
// Shared defaults and FSM encoding for the audio capture buffer.
package audio_pkg;

  localparam int unsigned DATA_W      = 24;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned NUM_SAMPLES = 520;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
module capture_ram #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  // No reset: contents survive reset and rd_data is undefined until the first read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/audio_capture_buffer.sv
// Captures NUM_SAMPLES mono-mixed codec samples into a RAM for later readout.
module audio_capture_buffer #(
  parameter int unsigned DATA_W      = audio_pkg::DATA_W,
  parameter int unsigned ADDR_W      = audio_pkg::ADDR_W,
  parameter int unsigned NUM_SAMPLES = audio_pkg::NUM_SAMPLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  import audio_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_SAMPLES - 1);

  capture_state_t    state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en;
  logic [DATA_W:0]   mix_sum;
  logic [DATA_W-1:0] mix;

  // Sum at DATA_W+1 bits cannot overflow; dropping bit 0 is the arithmetic halve.
  always_comb begin
    mix_sum = {readdata_left[DATA_W-1], readdata_left}
            + {readdata_right[DATA_W-1], readdata_right};
    mix     = mix_sum[DATA_W:1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CAPTURE;
          wr_addr_d = '0;
        end
      end
      CAPTURE: begin
        if (read_ready) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == LastAddr) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The codec FIFO is always drained; pops outside CAPTURE are simply dropped.
  always_comb begin
    read = read_ready;
    busy = (state_q == CAPTURE);
    done = (state_q == DONE);
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_addr_q),
    .wr_data (mix),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
